// File: rtl/ara_testharness.sv
// Self-test harness: fills a scratch memory with a per-word pattern, reads it back,
// counts mismatches and reports {mismatch_count, done} on exit_o with the run length.
module ara_testharness #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64*NrLanes/2,
  parameter int unsigned MemWords     = 16,
  parameter int          FaultAddr    = -1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [63:0] exit_o
);

  localparam int unsigned AddrW = (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned CntW  = 9;

  if (!(NrLanes == 2 || NrLanes == 4 || NrLanes == 8 || NrLanes == 16)) begin : g_err_lanes
    $error("ara_testharness: NrLanes must be 2, 4, 8 or 16");
  end
  if (AxiDataWidth != 32*NrLanes) begin : g_err_width
    $error("ara_testharness: AxiDataWidth must equal 32*NrLanes");
  end
  if (MemWords < 2 || MemWords > 256) begin : g_err_depth
    $error("ara_testharness: MemWords must be in 2..256");
  end

  typedef logic [AxiDataWidth-1:0] word_t;
  typedef enum logic [1:0] {WRITE, READ, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [AxiAddrWidth-1:0] addr_q, addr_d;
  logic [AxiAddrWidth-1:0] rd_addr_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [63:0]             runtime_buf_q, runtime_buf_d;
  logic [63:0]             exit_q, exit_d;
  logic                    rd_vld_q;
  logic                    we, re, last, fault;

  word_t                   mem_q [MemWords];
  word_t                   rdata_q, wdata;
  logic [NrLanes-1:0][31:0] wlane, rlane;
  logic [NrLanes-1:0]      lane_mis;
  logic [31:0]             widx, ridx;

  assign widx  = 32'(addr_q);
  assign ridx  = 32'(rd_addr_q);
  assign last  = (addr_q == AxiAddrWidth'(MemWords - 1));
  assign fault = (FaultAddr >= 0) && (addr_q == AxiAddrWidth'(FaultAddr));

  // Each 64-bit slice is {i, ~i}: even 32-bit lanes carry ~i, odd lanes carry i.
  for (genvar l = 0; l < NrLanes; l++) begin : g_lane
    if (l % 2 == 1) begin : g_odd
      assign wlane[l]    = widx;
      assign lane_mis[l] = (rlane[l] != ridx);
    end else begin : g_even
      assign wlane[l]    = ~widx;
      assign lane_mis[l] = (rlane[l] != ~ridx);
    end
  end

  assign wdata = word_t'(wlane) ^ word_t'(fault);
  assign rlane = rdata_q;

  // Contents are not reset; every run rewrites all words before reading them.
  always_ff @(posedge clk_i) begin
    if (we) mem_q[addr_q[AddrW-1:0]] <= wdata;
    if (re) rdata_q <= mem_q[addr_q[AddrW-1:0]];
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    exit_d        = exit_q;
    runtime_buf_d = runtime_buf_q + 64'd1;
    we            = 1'b0;
    re            = 1'b0;
    cnt_d         = cnt_q;
    if (rd_vld_q && (|lane_mis) && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      WRITE: begin
        we     = 1'b1;
        addr_d = last ? '0 : addr_q + 1'b1;
        if (last) state_d = READ;
      end
      READ: begin
        re     = 1'b1;
        addr_d = last ? '0 : addr_q + 1'b1;
        if (last) state_d = DRAIN;
      end
      DRAIN: begin
        // cnt_d already folds in the last read's compare
        state_d = DONE;
        exit_d  = {63'(cnt_d), 1'b1};
      end
      DONE: runtime_buf_d = runtime_buf_q;
      default: state_d = WRITE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= WRITE;
      addr_q        <= '0;
      rd_addr_q     <= '0;
      rd_vld_q      <= 1'b0;
      cnt_q         <= '0;
      runtime_buf_q <= '0;
      exit_q        <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rd_addr_q     <= addr_q;
      rd_vld_q      <= re;
      cnt_q         <= cnt_d;
      runtime_buf_q <= runtime_buf_d;
      exit_q        <= exit_d;
    end
  end

  assign exit_o = exit_q;

endmodule

// File: tb/tb_ara_testharness.sv
// Directed bench: default, fault-injected and 16-lane harnesses on one clock/reset.
module tb_ara_testharness;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] exit_def, exit_flt, exit_wide;
  int          n_chk = 0;
  int          n_err = 0;
  int          c;

  always #5 clk = ~clk;

  ara_testharness d_def (.clk_i(clk), .rst_ni(rst_n), .exit_o(exit_def));
  ara_testharness #(.FaultAddr(5)) d_flt (.clk_i(clk), .rst_ni(rst_n), .exit_o(exit_flt));
  ara_testharness #(.NrLanes(16), .AxiDataWidth(512), .MemWords(8))
    d_wide (.clk_i(clk), .rst_ni(rst_n), .exit_o(exit_wide));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset(3);
    chk("rst_exit", exit_def, 64'h0);
    chk("rst_rt", d_def.runtime_buf_q, 64'd0);
    chk("rst_exit_wide", exit_wide, 64'h0);

    for (int k = 1; k <= 40; k++) begin
      step();
      case (k)
        10: begin
          chk("mid_rt", d_def.runtime_buf_q, 64'd10);
          chk("mid_exit", exit_def, 64'h0);
        end
        16: begin
          chk("wide_exit_pre", exit_wide, 64'h0);
          chk("wide_rt_pre", d_wide.runtime_buf_q, 64'd16);
        end
        17: begin
          chk("wide_exit", exit_wide, 64'h1);
          chk("wide_rt", d_wide.runtime_buf_q, 64'd17);
        end
        32: begin
          chk("def_exit_pre", exit_def, 64'h0);
          chk("flt_exit_pre", exit_flt, 64'h0);
        end
        33: begin
          chk("def_exit", exit_def, 64'h1);
          chk("def_rt", d_def.runtime_buf_q, 64'd33);
          chk("flt_exit", exit_flt, 64'h3);
          chk("flt_rt", d_flt.runtime_buf_q, 64'd33);
        end
        40: begin
          chk("def_exit_hold", exit_def, 64'h1);
          chk("wide_rt_hold", d_wide.runtime_buf_q, 64'd17);
        end
        default: ;
      endcase
    end

    repeat (100) step();
    chk("done_exit_100", exit_def, 64'h1);
    chk("done_rt_100", d_def.runtime_buf_q, 64'd33);
    chk("done_flt_100", exit_flt, 64'h3);

    // Reset out of DONE, then abort again partway through READ.
    do_reset(1);
    chk("rst_done_exit", exit_def, 64'h0);
    chk("rst_done_rt", d_def.runtime_buf_q, 64'd0);
    repeat (20) step();
    chk("read_rt", d_def.runtime_buf_q, 64'd20);
    chk("read_exit", exit_def, 64'h0);
    rst_n = 1'b0;
    step();
    chk("abort_exit", exit_def, 64'h0);
    chk("abort_rt", d_def.runtime_buf_q, 64'd0);
    rst_n = 1'b1;

    c = 0;
    while (!exit_def[0] && c < 100) begin
      step();
      c++;
    end
    chk("done_seen", 64'(exit_def[0]), 64'h1);
    chk("run_len", 64'(c), 64'd33);
    chk("rerun_exit", exit_def, 64'h1);
    chk("rerun_rt", d_def.runtime_buf_q, 64'd33);
    chk("rerun_flt", exit_flt, 64'h3);

    $display("tohost=%0d (%s) runtime_buf_q=%0d", exit_def[63:1],
             (exit_def[63:1] == 63'd0) ? "pass" : "mismatches", d_def.runtime_buf_q);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
